// File: rtl/unpack_float64.sv
// unpack_float64: splits a binary64 word into sign/exponent/significand, normalizing subnormals
// Ports: ap_clk/ap_rst (sync, active-high), ap_start/ap_done/ap_idle/ap_ready block handshake,
//        a operand, float_exception_flag_i/_o/_o_ap_vld sticky flags, zSign/zExp/zSig/zClass result.
// Define UNPACK_SNAN_FLAG_EN to raise INVALID_FLAG on a signalling NaN.
module unpack_float64 #(
  parameter int          NORM_SHIFT   = 1,
  parameter logic [31:0] INVALID_FLAG = 32'd16
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] a,
  input  logic [31:0] float_exception_flag_i,
  output logic [31:0] float_exception_flag_o,
  output logic        float_exception_flag_o_ap_vld,
  output logic        zSign,
  output logic [11:0] zExp,
  output logic [63:0] zSig,
  output logic [2:0]  zClass
);
  typedef enum logic [3:0] {IDLE = 4'b0001, DECODE = 4'b0010, NORM = 4'b0100, DONE = 4'b1000} state_t;
  state_t state;
  logic [63:0] a_r;
  logic [52:0] sig, sig_n;
  logic [11:0] exp_r, exp_n;
  logic [10:0] e;
  logic [51:0] f;
  logic        wide;
  assign e = a_r[62:52];
  assign f = a_r[51:0];
  // a wide step is only taken when it cannot move a set bit past bit 52
  assign wide  = sig[52 -: NORM_SHIFT] == '0;
  assign sig_n = wide ? sig << NORM_SHIFT : sig << 1;
  assign exp_n = wide ? exp_r - 12'(NORM_SHIFT) : exp_r - 12'd1;
  assign ap_done  = state == DONE;
  assign ap_ready = ap_done;
  assign ap_idle  = state == IDLE && !ap_start;
`ifdef UNPACK_SNAN_FLAG_EN
  assign float_exception_flag_o_ap_vld = ap_done && zClass == 3'd5;
`else
  assign float_exception_flag_o_ap_vld = 1'b0;
`endif
  assign float_exception_flag_o = float_exception_flag_o_ap_vld ? float_exception_flag_i | INVALID_FLAG
                                                                : float_exception_flag_i;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state  <= IDLE;
      a_r    <= '0;
      sig    <= '0;
      exp_r  <= '0;
      zSign  <= 1'b0;
      zExp   <= '0;
      zSig   <= '0;
      zClass <= '0;
    end else begin
      case (state)
        IDLE: if (ap_start) begin
          a_r   <= a;
          state <= DECODE;
        end
        DECODE: begin
          if (e == '0 && f != '0) begin
            sig   <= {1'b0, f};
            exp_r <= 12'd1;
            state <= NORM;
          end else begin
            zSign <= a_r[63];
            state <= DONE;
            if (e == '0) begin
              zExp   <= '0;
              zSig   <= '0;
              zClass <= 3'd0;
            end else if (e != 11'h7FF) begin
              zExp   <= {1'b0, e};
              zSig   <= {2'b01, f, 10'b0};
              zClass <= 3'd2;
            end else begin
              zExp   <= 12'h7FF;
              zSig   <= {2'b00, f, 10'b0};
              zClass <= f == '0 ? 3'd3 : f[51] ? 3'd4 : 3'd5;
            end
          end
        end
        NORM: begin
          sig   <= sig_n;
          exp_r <= exp_n;
          if (sig_n[52]) begin
            zSign  <= a_r[63];
            zExp   <= exp_n;
            zSig   <= {1'b0, sig_n, 10'b0};
            zClass <= 3'd1;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unpack_float64.sv
// tb_unpack_float64: randomized and directed checks of unpack_float64 against a behavioural model
module tb_unpack_float64;
  logic        ap_clk = 0, ap_rst = 1, ap_start = 0;
  logic        ap_done, ap_idle, ap_ready, vld, zSign;
  logic [63:0] a = '0, zSig;
  logic [31:0] flag_i = '0, flag_o;
  logic [11:0] zExp;
  logic [2:0]  zClass;
  int tests = 0, fails = 0;
`ifdef UNPACK_SNAN_FLAG_EN
  localparam bit EN = 1;
`else
  localparam bit EN = 0;
`endif
  unpack_float64 dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .a(a), .float_exception_flag_i(flag_i), .float_exception_flag_o(flag_o),
    .float_exception_flag_o_ap_vld(vld), .zSign(zSign), .zExp(zExp), .zSig(zSig), .zClass(zClass)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [63:0] av, output logic [11:0] ze, output logic [63:0] zs,
                                output logic [2:0] zc, output int lat);
    int e = int'(av[62:52]);
    logic [51:0] f = av[51:0];
    int p = 0;
    lat = 2;
    if (e == 0 && f == 0) begin
      ze = 0; zs = 0; zc = 0;
    end else if (e == 0) begin
      for (int i = 0; i < 52; i++) if (f[i]) p = i;
      ze = 12'(1 - (52 - p));
      zs = 64'(f) << (62 - p);
      zc = 1;
      lat = 2 + 52 - p;
    end else if (e < 2047) begin
      ze = 12'(e);
      zs = (64'(f) + 64'h0010_0000_0000_0000) * 1024;
      zc = 2;
    end else begin
      ze = 12'd2047;
      zs = 64'(f) * 1024;
      zc = f == 0 ? 3'd3 : f[51] ? 3'd4 : 3'd5;
    end
  endfunction
  task automatic check_result(input logic [63:0] av, input logic [31:0] fi);
    logic [11:0] ze;
    logic [63:0] zs;
    logic [2:0]  zc;
    int lat;
    bit v;
    model(av, ze, zs, zc, lat);
    v = EN && zc == 5;
    check("sign", zSign, av[63]);
    check("exp", zExp, ze);
    check("sig", zSig, zs);
    check("class", zClass, zc);
    check("ready", ap_ready, 1);
    check("vld", vld, v);
    check("flag_o", flag_o, v ? fi | 32'd16 : fi);
  endtask
  task automatic run(input logic [63:0] av, input logic [31:0] fi);
    logic [11:0] ze;
    logic [63:0] zs;
    logic [2:0]  zc;
    int lat, n = 0;
    model(av, ze, zs, zc, lat);
    @(negedge ap_clk);
    a = av; flag_i = fi; ap_start = 1;
    @(posedge ap_clk);
    #1 ap_start = 0; a = {$urandom, $urandom};
    while (n < 100) begin
      @(negedge ap_clk);
      n++;
      if (ap_done) break;
      if (vld) check("early_vld", vld, 0);
    end
    check("latency", n, lat);
    check_result(av, fi);
    @(negedge ap_clk);
    check("done_pulse", ap_done, 0);
    check("idle_after", ap_idle, 1);
    check("flag_pass", flag_o, fi);
  endtask
  initial begin
    int n, d1, d2, pulses;
    repeat (2) @(negedge ap_clk);
    check("rst_done", ap_done, 0);
    check("rst_idle", ap_idle, 1);
    check("rst_zexp", zExp, 0);
    check("rst_zsig", zSig, 0);
    check("rst_class", zClass, 0);
    ap_rst = 0;
    run(64'h3FF0000000000000, 0);
    check("one_exp", zExp, 12'h3FF);
    check("one_sig", zSig, 64'h4000000000000000);
    run(64'h0000000000000001, 0);
    check("min_exp", zExp, 12'hFCD);
    check("min_sig", zSig, 64'h4000000000000000);
    check("min_class", zClass, 1);
    run(64'h8000000000000000, 32'h5);
    run(64'h7FF0000000000001, 32'h1);
    check("snan_class", zClass, 5);
    run(64'h7FF0000000000000, 0);
    run(64'hFFF8000000000000, 0);
    run(64'h000FFFFFFFFFFFFF, 0);
    run(64'h7FEFFFFFFFFFFFFF, 0);
    run(64'h8010000000000000, 0);
    for (int i = 0; i < 40; i++) begin
      logic [63:0] r = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: begin r[62:52] = '0; r[51:0] = r[51:0] >> $urandom_range(0, 51); end
        1: r[62:52] = 11'h7FF;
        default: ;
      endcase
      run(r, $urandom);
    end
    // back-to-back with start held high
    @(negedge ap_clk);
    a = 64'h7FF8000000000000; flag_i = 0; ap_start = 1;
    @(posedge ap_clk);
    #1 a = 64'h0008000000000000;
    n = 0; d1 = 0; d2 = 0;
    while (n < 20 && d2 == 0) begin
      @(negedge ap_clk);
      n++;
      if (n == 3) check("b2b_idle_low", ap_idle, 0);
      if (ap_done && d1 == 0) begin d1 = n; check_result(64'h7FF8000000000000, 0); end
      else if (ap_done) begin d2 = n; check_result(64'h0008000000000000, 0); end
    end
    ap_start = 0;
    check("b2b_first", d1, 2);
    check("b2b_second", d2, 6);
    check("b2b_exp", zExp, 12'h000);
    // reset during the third NORM cycle of a long normalization
    run(64'hBFF0000000000000, 0);
    @(negedge ap_clk);
    a = 64'h0000000000000001; ap_start = 1;
    @(posedge ap_clk);
    #1 ap_start = 0;
    repeat (4) @(negedge ap_clk);
    ap_rst = 1;
    @(negedge ap_clk);
    ap_rst = 0;
    check("mid_rst_done", ap_done, 0);
    check("mid_rst_idle", ap_idle, 1);
    check("mid_rst_sign", zSign, 0);
    check("mid_rst_exp", zExp, 0);
    check("mid_rst_sig", zSig, 0);
    check("mid_rst_class", zClass, 0);
    pulses = 0;
    repeat (60) begin
      @(negedge ap_clk);
      if (ap_done || vld) pulses++;
    end
    check("mid_rst_no_done", pulses, 0);
    run(64'h0000000000000003, 32'h2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
